// File: rtl/np_pkg.sv
// Shared types for the Neopixel frame scheduler: FSM states, index width and colour struct.
package np_pkg;

  localparam int unsigned NP_IDX_W = 5;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_RDY  = 3'd1,
    LOAD      = 3'd2,
    GO        = 3'd3,
    SETTLE    = 3'd4,
    BUSY_WAIT = 3'd5
  } np_sched_state_t;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } rgb_t;

endpackage

// File: rtl/np_rr_arbiter2.sv
// Two-way round-robin arbiter; a tie goes to the requester not granted last.
module np_rr_arbiter2 (
  input  logic clock,
  input  logic reset,
  input  logic req_a_i,
  input  logic req_b_i,
  output logic grant_a_o,
  output logic grant_b_o
);

  logic last_b_q;
  logic last_b_d;

  always_comb begin
    grant_a_o = req_a_i & (~req_b_i | last_b_q);
    grant_b_o = req_b_i & ~grant_a_o;
    last_b_d  = last_b_q;
    if (grant_a_o) begin
      last_b_d = 1'b0;
    end else if (grant_b_o) begin
      last_b_d = 1'b1;
    end
  end

  // Pointer starts at B so that A wins the first tie.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_b_q <= 1'b1;
    end else begin
      last_b_q <= last_b_d;
    end
  end

endmodule

// File: rtl/np_frame_scheduler.sv
// Shares one Neopixel strand between two requesters: shadows pixel colours and
// streams a full frame to the downstream controller when dirty and rate-allowed.
module np_frame_scheduler
  import np_pkg::*;
#(
  parameter int unsigned NUM_PIXELS     = 16,
  parameter logic [19:0] REFRESH_CYCLES = 20'd833_333
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                a_valid,
  input  logic [NP_IDX_W-1:0] a_pixel,
  input  logic [23:0]         a_rgb,
  output logic                a_ack,
  input  logic                b_valid,
  input  logic [NP_IDX_W-1:0] b_pixel,
  input  logic [23:0]         b_rgb,
  output logic                b_ack,
  input  logic                force_refresh,
  output logic [7:0]          np_red,
  output logic [7:0]          np_green,
  output logic [7:0]          np_blue,
  output logic [NP_IDX_W-1:0] np_pixel,
  output logic                np_load,
  output logic                np_go,
  input  logic                np_ready,
  output logic                busy,
  output logic [15:0]         frames_sent
);

  localparam int unsigned         SH_IDX_W = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam logic [NP_IDX_W-1:0] LAST_IDX = NP_IDX_W'(NUM_PIXELS - 1);

  np_rr_arbiter2 u_arb (
    .clock     (clock),
    .reset     (reset),
    .req_a_i   (a_valid),
    .req_b_i   (b_valid),
    .grant_a_o (a_ack),
    .grant_b_o (b_ack)
  );

  logic [NP_IDX_W-1:0] wr_pixel;
  rgb_t                wr_rgb;
  logic                wr_keep;

  always_comb begin
    wr_pixel = b_ack ? b_pixel : a_pixel;
    wr_rgb   = b_ack ? b_rgb : a_rgb;
    wr_keep  = (a_ack | b_ack) && (32'(wr_pixel) < NUM_PIXELS);
  end

  rgb_t shadow_q [NUM_PIXELS];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_PIXELS; i++) begin
        shadow_q[i] <= '0;
      end
    end else if (wr_keep) begin
      shadow_q[wr_pixel[SH_IDX_W-1:0]] <= wr_rgb;
    end
  end

  np_sched_state_t     state_q, state_d;
  logic [NP_IDX_W-1:0] idx_q, idx_d;
  logic                dirty_q, dirty_d;
  logic                force_q, force_d;
  logic [19:0]         interval_q, interval_d;
  logic [15:0]         frames_q, frames_d;
  logic                elapsed;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    dirty_d    = dirty_q;
    force_d    = force_q;
    elapsed    = (interval_q == '0);
    interval_d = interval_q;
    frames_d   = frames_q;

    if (state_q == GO) begin
      interval_d = REFRESH_CYCLES - 20'd1;
      frames_d   = frames_q + 16'd1;
    end else if (!elapsed) begin
      interval_d = interval_q - 20'd1;
    end

    case (state_q)
      IDLE:      if ((dirty_q || force_q) && elapsed) state_d = WAIT_RDY;
      WAIT_RDY: begin
        if (np_ready) begin
          state_d = LOAD;
          idx_d   = '0;
          dirty_d = 1'b0;
          force_d = 1'b0;
        end
      end
      LOAD: begin
        if (idx_q == LAST_IDX) begin
          state_d = GO;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      GO:        state_d = SETTLE;
      SETTLE:    state_d = BUSY_WAIT;
      BUSY_WAIT: if (np_ready) state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    // New requests override the clear taken on the WAIT_RDY->LOAD transition.
    if (wr_keep) dirty_d = 1'b1;
    if (force_refresh) force_d = 1'b1;
  end

  logic                load_q, go_q, busy_q;
  logic [NP_IDX_W-1:0] pixel_q;
  rgb_t                out_rgb_q;

  // Downstream outputs are registered from the next state, so each LOAD cycle
  // presents the shadow value held before that cycle's write lands.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      dirty_q    <= 1'b0;
      force_q    <= 1'b0;
      interval_q <= '0;
      frames_q   <= '0;
      load_q     <= 1'b0;
      go_q       <= 1'b0;
      busy_q     <= 1'b0;
      pixel_q    <= '0;
      out_rgb_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      dirty_q    <= dirty_d;
      force_q    <= force_d;
      interval_q <= interval_d;
      frames_q   <= frames_d;
      load_q     <= (state_d == LOAD);
      go_q       <= (state_d == GO);
      busy_q     <= (state_d != IDLE);
      if (state_d == LOAD) begin
        pixel_q   <= idx_d;
        out_rgb_q <= shadow_q[idx_d[SH_IDX_W-1:0]];
      end
    end
  end

  assign np_load     = load_q;
  assign np_go       = go_q;
  assign busy        = busy_q;
  assign np_pixel    = pixel_q;
  assign np_red      = out_rgb_q.red;
  assign np_green    = out_rgb_q.green;
  assign np_blue     = out_rgb_q.blue;
  assign frames_sent = frames_q;

endmodule
